tex_req_arbiter: RTL and testbench
==================================

Name: tex_req_arbiter

Overview:
- Sits between the per-core texture agents and a shared texture unit.
- Arbitrates NUM_REQS texture request streams round-robin onto one request port. The requester index is appended to the low bits of the tag.
- Routes texture responses back to the originating requester by that index and strips it from the tag.
- Both directions are registered with full-throughput valid/ready elastic buffering.

Parameters:
- NUM_REQS, 4, number of upstream requesters (≥1)
- NUM_THREADS, 4, lanes per request
- LOD_BITS, 4, per-lane LOD width
- STAGE_BITS, 1, sampler stage index width
- TAG_WIDTH, 16, upstream tag width
- SEL_BITS, derived: log2 of NUM_REQS rounded up, 0 when NUM_REQS=1; output tag width TAG_WIDTH+SEL_BITS

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid_in  in  NUM_REQS  per-requester request valid
- req_ready_in  out  NUM_REQS  per-requester request ready
- req_mask_in  in  NUM_REQS*NUM_THREADS  lane masks
- req_coords_in  in  NUM_REQS*2*NUM_THREADS*32  u,v coordinates
- req_lod_in  in  NUM_REQS*NUM_THREADS*LOD_BITS  LODs
- req_stage_in  in  NUM_REQS*STAGE_BITS  stage
- req_tag_in  in  NUM_REQS*TAG_WIDTH  tags
- req_valid_out  out  1  merged request valid
- req_ready_out  in  1  texture unit ready
- req_mask_out / req_coords_out / req_lod_out / req_stage_out  out  single-slice widths  granted payload
- req_tag_out  out  TAG_WIDTH+SEL_BITS  {tag, requester index}
- rsp_valid_in  in  1  texture unit response valid
- rsp_ready_in  out  1  response accepted
- rsp_texels_in  in  NUM_THREADS*32  texels
- rsp_tag_in  in  TAG_WIDTH+SEL_BITS  returned tag
- rsp_valid_out  out  NUM_REQS  per-requester response valid
- rsp_ready_out  in  NUM_REQS  per-requester response ready
- rsp_texels_out  out  NUM_REQS*NUM_THREADS*32  texels
- rsp_tag_out  out  NUM_REQS*TAG_WIDTH  stripped tags

Behaviour:
- **Reset:**
  - req_valid_out=0 and all rsp_valid_out=0.
  - Round-robin pointer=0. All skid entries are empty.
  - Payload outputs are don't-care while valid is low.
  - Reset mid-transfer drops all buffered entries. No handshake completes in the reset cycle.
- **Request arbitration:**
  - Combinational round-robin grant among asserted req_valid_in.
  - Priority starts at the pointer and proceeds in increasing index order with wrap-around.
  - req_ready_in[i] = grant[i] and the output buffer can accept. At most one bit is high per cycle.
  - The grant is stable while the output buffer is stalled.
  - On a handshake of requester g, the pointer becomes (g+1) mod NUM_REQS. With no handshake the pointer holds.
  - The valid-to-ready dependency is acyclic: req_ready_in never depends on req_valid_in of the same index through the output buffer.
- **Request output:**
  - Two-entry skid buffer with registered outputs. Latency is 1 cycle from accept to req_valid_out.
  - Sustains 1 request/cycle while req_ready_out=1.
  - req_tag_out = {req_tag_in[g], g[SEL_BITS-1:0]}.
  - When req_ready_out=0, payload and valid hold unchanged.
- **Response routing:**
  - sel = rsp_tag_in[SEL_BITS-1:0], or 0 when SEL_BITS=0.
  - Each requester has its own two-entry registered skid buffer.
  - rsp_ready_in = that requester's buffer can accept. A stalled requester only blocks responses addressed to it, and only while its buffer is full.
  - Latency is 1 cycle. rsp_tag_out[sel] = rsp_tag_in[TAG_WIDTH+SEL_BITS-1:SEL_BITS]. Texels pass unchanged.
  - sel ≥ NUM_REQS (non-power-of-two NUM_REQS) is illegal. It is caught by a simulation assertion and the response is dropped (rsp_ready_in=1).
- **NUM_REQS=1:**
  - Degenerates to a registered pass-through in both directions. The tag is unmodified.
- **Independence:** the request and response paths share no state. Simultaneous request and response handshakes in the same cycle are fully independent.
- **Assertions:**
  - req_ready_in is at most one-hot.
  - A valid output holds payload stable until ready.

Test Plan:
- NUM_REQS=4, all four valid continuously, req_ready_out=1 → grants in order 0,1,2,3,0,…. req_tag_out low 2 bits cycle 00,01,10,11. One output per cycle after a 1-cycle latency.
- Only requester 2 valid with tag 0x1234 → req_tag_out=0x48D2 one cycle later. Pointer then becomes 3, so requester 3 wins a following tie with requester 0.
- req_ready_out=0 for 5 cycles with requesters 1 and 3 valid → at most 2 requests accepted. Output payload stays stable. Nothing is lost or duplicated after release.
- Responses with tags 0x48D2, then 0x0001 → requester 2 receives tag 0x1234, then requester 1 receives tag 0x0000. Texels match. Each arrives 1 cycle after acceptance.
- rsp_ready_out[1]=0 held, three responses to requester 1 interleaved with responses to requester 0 → requester 0 sees no stall. rsp_ready_in drops only when a requester-1 response meets a full buffer.
- Assert reset with requests buffered on both paths → all valid outputs are 0 on the next cycle and the pointer is 0. A fresh request after reset is granted to the lowest valid index.

Source files
------------

// File: rtl/tex_req_arbiter.sv
// Round-robin merge of per-core texture requests onto one texture unit port, with responses
// routed back by the requester index carried in the low tag bits. Both directions are skid-buffered.

module tex_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_valid;
  logic [W-1:0] skid_data;

  // Ready comes from a register only, so upstream never sees a combinational path from out_ready.
  assign in_ready = !skid_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && in_ready) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

  a_out_stable: assert property (@(posedge clk) disable iff (reset)
    out_valid && !out_ready |=> out_valid && $stable(out_data));
endmodule

module tex_req_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_THREADS = 4,
  parameter int LOD_BITS    = 4,
  parameter int STAGE_BITS  = 1,
  parameter int TAG_WIDTH   = 16,
  localparam int SEL_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
  localparam int OTW        = TAG_WIDTH + SEL_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQS-1:0]                   req_valid_in,
  output logic [NUM_REQS-1:0]                   req_ready_in,
  input  logic [NUM_REQS*NUM_THREADS-1:0]       req_mask_in,
  input  logic [NUM_REQS*2*NUM_THREADS*32-1:0]  req_coords_in,
  input  logic [NUM_REQS*NUM_THREADS*LOD_BITS-1:0] req_lod_in,
  input  logic [NUM_REQS*STAGE_BITS-1:0]        req_stage_in,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]         req_tag_in,
  output logic                                  req_valid_out,
  input  logic                                  req_ready_out,
  output logic [NUM_THREADS-1:0]                req_mask_out,
  output logic [2*NUM_THREADS*32-1:0]           req_coords_out,
  output logic [NUM_THREADS*LOD_BITS-1:0]       req_lod_out,
  output logic [STAGE_BITS-1:0]                 req_stage_out,
  output logic [OTW-1:0]                        req_tag_out,
  input  logic                                  rsp_valid_in,
  output logic                                  rsp_ready_in,
  input  logic [NUM_THREADS*32-1:0]             rsp_texels_in,
  input  logic [OTW-1:0]                        rsp_tag_in,
  output logic [NUM_REQS-1:0]                   rsp_valid_out,
  input  logic [NUM_REQS-1:0]                   rsp_ready_out,
  output logic [NUM_REQS*NUM_THREADS*32-1:0]    rsp_texels_out,
  output logic [NUM_REQS*TAG_WIDTH-1:0]         rsp_tag_out
);
  localparam int PTR_W = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int MSK_W = NUM_THREADS;
  localparam int CRD_W = 2 * NUM_THREADS * 32;
  localparam int LOD_W = NUM_THREADS * LOD_BITS;
  localparam int TEX_W = NUM_THREADS * 32;
  localparam int REQ_W = MSK_W + CRD_W + LOD_W + STAGE_BITS + OTW;
  localparam int RSP_W = TEX_W + TAG_WIDTH;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQS - 1);

  logic [PTR_W-1:0] rr_ptr, grant_idx;
  logic             grant_vld, req_buf_rdy;
  logic [REQ_W-1:0] req_buf_dat, req_out_dat;
  logic [OTW-1:0]   grant_tag;
  int               idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQS;
      if (!grant_vld && req_valid_in[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++)
      req_ready_in[i] = grant_vld && req_buf_rdy && (grant_idx == PTR_W'(i));
  end

  generate
    if (SEL_BITS > 0) begin : g_tag_sel
      assign grant_tag = {req_tag_in[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH], grant_idx};
    end else begin : g_tag_pass
      assign grant_tag = req_tag_in[TAG_WIDTH-1:0];
    end
  endgenerate

  assign req_buf_dat = {req_mask_in[int'(grant_idx)*MSK_W +: MSK_W],
                        req_coords_in[int'(grant_idx)*CRD_W +: CRD_W],
                        req_lod_in[int'(grant_idx)*LOD_W +: LOD_W],
                        req_stage_in[int'(grant_idx)*STAGE_BITS +: STAGE_BITS],
                        grant_tag};

  // Pointer moves past the winner only on an actual handshake, which keeps the grant stable under stall.
  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (grant_vld && req_buf_rdy)
      rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + PTR_W'(1);
  end

  tex_skid_buf #(.W(REQ_W)) u_req_buf (
    .clk(clk), .reset(reset),
    .in_valid(grant_vld), .in_ready(req_buf_rdy), .in_data(req_buf_dat),
    .out_valid(req_valid_out), .out_ready(req_ready_out), .out_data(req_out_dat)
  );

  assign {req_mask_out, req_coords_out, req_lod_out, req_stage_out, req_tag_out} = req_out_dat;

  logic [PTR_W-1:0]     rsp_sel;
  logic [NUM_REQS-1:0]  rsp_buf_rdy;
  logic [RSP_W-1:0]     rsp_out_dat [NUM_REQS];

  generate
    if (SEL_BITS > 0) begin : g_rsp_sel
      assign rsp_sel = rsp_tag_in[PTR_W-1:0];
    end else begin : g_rsp_zero
      assign rsp_sel = '0;
    end
  endgenerate

  // An out-of-range index matches no buffer and leaves ready high, so the response is dropped.
  always_comb begin
    rsp_ready_in = !reset;
    for (int i = 0; i < NUM_REQS; i++)
      if (rsp_sel == PTR_W'(i)) rsp_ready_in = rsp_buf_rdy[i];
  end

  generate
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_rsp
      tex_skid_buf #(.W(RSP_W)) u_rsp_buf (
        .clk(clk), .reset(reset),
        .in_valid(rsp_valid_in && (rsp_sel == PTR_W'(i))), .in_ready(rsp_buf_rdy[i]),
        .in_data({rsp_texels_in, rsp_tag_in[OTW-1:SEL_BITS]}),
        .out_valid(rsp_valid_out[i]), .out_ready(rsp_ready_out[i]), .out_data(rsp_out_dat[i])
      );
      assign {rsp_texels_out[i*TEX_W +: TEX_W], rsp_tag_out[i*TAG_WIDTH +: TAG_WIDTH]} = rsp_out_dat[i];
    end
  endgenerate

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready_in));
  a_rsp_sel_legal: assert property (@(posedge clk) disable iff (reset)
    rsp_valid_in |-> int'(rsp_sel) < NUM_REQS);
endmodule

// File: tb/tb_tex_req_arbiter.sv
// Directed vector bench for tex_req_arbiter at NUM_REQS=4: arbitration order, stalls, response routing, reset.
module tb_tex_req_arbiter;
  localparam int NR = 4, NT = 4, TW = 16, OTW = 18;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NR-1:0]       req_valid_in, req_ready_in;
  logic [NR*NT-1:0]    req_mask_in;
  logic [NR*256-1:0]   req_coords_in;
  logic [NR*16-1:0]    req_lod_in;
  logic [NR-1:0]       req_stage_in;
  logic [NR*TW-1:0]    req_tag_in;
  logic                req_valid_out, req_ready_out;
  logic [NT-1:0]       req_mask_out;
  logic [255:0]        req_coords_out;
  logic [15:0]         req_lod_out;
  logic [0:0]          req_stage_out;
  logic [OTW-1:0]      req_tag_out;
  logic                rsp_valid_in, rsp_ready_in;
  logic [127:0]        rsp_texels_in;
  logic [OTW-1:0]      rsp_tag_in;
  logic [NR-1:0]       rsp_valid_out, rsp_ready_out;
  logic [NR*128-1:0]   rsp_texels_out;
  logic [NR*TW-1:0]    rsp_tag_out;

  tex_req_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_ready_in(req_ready_in), .req_mask_in(req_mask_in),
    .req_coords_in(req_coords_in), .req_lod_in(req_lod_in), .req_stage_in(req_stage_in),
    .req_tag_in(req_tag_in), .req_valid_out(req_valid_out), .req_ready_out(req_ready_out),
    .req_mask_out(req_mask_out), .req_coords_out(req_coords_out), .req_lod_out(req_lod_out),
    .req_stage_out(req_stage_out), .req_tag_out(req_tag_out),
    .rsp_valid_in(rsp_valid_in), .rsp_ready_in(rsp_ready_in), .rsp_texels_in(rsp_texels_in),
    .rsp_tag_in(rsp_tag_in), .rsp_valid_out(rsp_valid_out), .rsp_ready_out(rsp_ready_out),
    .rsp_texels_out(rsp_texels_out), .rsp_tag_out(rsp_tag_out)
  );

  typedef struct packed {
    logic [3:0]  vld;
    logic [63:0] tags;
    logic        rd;
    logic        rv;
    logic [17:0] rtag;
    logic [3:0]  rrdy;
    logic [3:0]  e_rdy;
    logic        e_v;
    logic [17:0] e_tag;
    logic        e_rrdy;
    logic [3:0]  e_rvout;
    logic [63:0] e_rtags;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t rq(logic [3:0] vld, logic [63:0] tags, logic rd,
                              logic [3:0] e_rdy, logic e_v, logic [17:0] e_tag);
    vec_t v;
    v = '0;
    v.vld = vld; v.tags = tags; v.rd = rd;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_tag = e_tag;
    v.rrdy = 4'hF; v.e_rrdy = 1'b1;
    return v;
  endfunction

  function automatic vec_t rs(logic rv, logic [17:0] rtag, logic [3:0] rrdy,
                              logic e_rrdy, logic [3:0] e_rvout, logic [63:0] e_rtags);
    vec_t v;
    v = '0;
    v.rd = 1'b1;
    v.rv = rv; v.rtag = rtag; v.rrdy = rrdy;
    v.e_rrdy = e_rrdy; v.e_rvout = e_rvout; v.e_rtags = e_rtags;
    return v;
  endfunction

  task automatic drive(input logic [3:0] vld, input logic [63:0] tags, input logic rd,
                       input logic rv, input logic [17:0] rtag, input logic [3:0] rrdy);
    req_valid_in  = vld;
    req_tag_in    = tags;
    req_ready_out = rd;
    for (int i = 0; i < NR; i++) begin
      req_mask_in[i*NT +: NT]     = tags[i*16 +: 4];
      req_coords_in[i*256 +: 256] = {8{tags[i*16 +: 16], tags[i*16 +: 16]}};
      req_lod_in[i*16 +: 16]      = tags[i*16 +: 16];
      req_stage_in[i]             = tags[i*16];
    end
    rsp_valid_in  = rv;
    rsp_tag_in    = rtag;
    rsp_texels_in = {4{14'h15A5, rtag}};
    rsp_ready_out = rrdy;
  endtask

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input vec_t v);
    check("req_valid_out", 512'(req_valid_out), 512'(v.e_v));
    if (v.e_v)
      check("req_payload",
            512'({req_tag_out, req_mask_out, req_coords_out[31:0], req_lod_out, req_stage_out}),
            512'({v.e_tag, v.e_tag[5:2], v.e_tag[17:2], v.e_tag[17:2], v.e_tag[17:2], v.e_tag[2]}));
    check("rsp_valid_out", 512'(rsp_valid_out), 512'(v.e_rvout));
    for (int i = 0; i < NR; i++)
      if (v.e_rvout[i])
        check("rsp_lane", 512'({rsp_tag_out[i*16 +: 16], rsp_texels_out[i*128 +: 128]}),
              512'({v.e_rtags[i*16 +: 16], {4{14'h15A5, v.e_rtags[i*16 +: 16], 2'(i)}}}));
  endtask

  localparam logic [63:0] T0 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] T1 = 64'h4444_1234_2222_1111;

  initial begin
    vec_t v;

    // Rotation with everyone requesting, then a lone requester 2, then the 3-vs-0 tie.
    vecs.push_back(rq(4'hF, T0, 1'b1, 4'b0001, 1'b1, 18'h04444));
    vecs.push_back(rq(4'hF, T0, 1'b1, 4'b0010, 1'b1, 18'h08889));
    vecs.push_back(rq(4'hF, T0, 1'b1, 4'b0100, 1'b1, 18'h0CCCE));
    vecs.push_back(rq(4'hF, T0, 1'b1, 4'b1000, 1'b1, 18'h11113));
    vecs.push_back(rq(4'hF, T0, 1'b1, 4'b0001, 1'b1, 18'h04444));
    vecs.push_back(rq(4'h0, T0, 1'b1, 4'b0000, 1'b0, 18'h0));
    vecs.push_back(rq(4'b0100, T1, 1'b1, 4'b0100, 1'b1, 18'h048D2));
    vecs.push_back(rq(4'b1001, T1, 1'b1, 4'b1000, 1'b1, 18'h11113));
    vecs.push_back(rq(4'h0, T1, 1'b1, 4'b0000, 1'b0, 18'h0));
    // Five stalled cycles with requesters 1 and 3: two accepted, output held, then drained in order.
    vecs.push_back(rq(4'b1010, T0, 1'b0, 4'b0010, 1'b1, 18'h08889));
    vecs.push_back(rq(4'b1010, T0, 1'b0, 4'b1000, 1'b1, 18'h08889));
    vecs.push_back(rq(4'b1010, T0, 1'b0, 4'b0000, 1'b1, 18'h08889));
    vecs.push_back(rq(4'b1010, T0, 1'b0, 4'b0000, 1'b1, 18'h08889));
    vecs.push_back(rq(4'b1010, T0, 1'b0, 4'b0000, 1'b1, 18'h08889));
    vecs.push_back(rq(4'h0, T0, 1'b1, 4'b0000, 1'b1, 18'h11113));
    vecs.push_back(rq(4'h0, T0, 1'b1, 4'b0000, 1'b0, 18'h0));
    // Response routing, with a simultaneous request in the first cycle.
    v = rs(1'b1, 18'h048D2, 4'hF, 1'b1, 4'b0100, 64'h0000_1234_0000_0000);
    v.vld = 4'b0001; v.tags = T0; v.e_rdy = 4'b0001; v.e_v = 1'b1; v.e_tag = 18'h04444;
    vecs.push_back(v);
    vecs.push_back(rs(1'b1, 18'h00001, 4'hF, 1'b1, 4'b0010, 64'h0));
    vecs.push_back(rs(1'b0, 18'h00000, 4'hF, 1'b1, 4'b0000, 64'h0));
    // Requester 1 stalled; requester 0 keeps flowing.
    vecs.push_back(rs(1'b1, 18'h28005, 4'b1101, 1'b1, 4'b0010, 64'h0000_0000_A001_0000));
    vecs.push_back(rs(1'b1, 18'h2C004, 4'b1101, 1'b1, 4'b0011, 64'h0000_0000_A001_B001));
    vecs.push_back(rs(1'b1, 18'h28009, 4'b1101, 1'b1, 4'b0010, 64'h0000_0000_A001_0000));
    vecs.push_back(rs(1'b1, 18'h2C008, 4'b1101, 1'b1, 4'b0011, 64'h0000_0000_A001_B002));
    vecs.push_back(rs(1'b1, 18'h2800D, 4'b1101, 1'b0, 4'b0010, 64'h0000_0000_A001_0000));
    vecs.push_back(rs(1'b1, 18'h2800D, 4'hF,    1'b0, 4'b0010, 64'h0000_0000_A002_0000));
    vecs.push_back(rs(1'b1, 18'h2800D, 4'hF,    1'b1, 4'b0010, 64'h0000_0000_A003_0000));
    vecs.push_back(rs(1'b1, 18'h2C00C, 4'hF,    1'b1, 4'b0001, 64'h0000_0000_0000_B003));
    vecs.push_back(rs(1'b0, 18'h00000, 4'hF,    1'b1, 4'b0000, 64'h0));

    reset = 1'b1;
    drive(4'h0, T0, 1'b1, 1'b0, 18'h0, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_state", 512'({req_valid_out, rsp_valid_out, req_ready_in, rsp_ready_in}),
          512'({1'b0, 4'b0000, 4'b0000, 1'b1}));

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].vld, vecs[k].tags, vecs[k].rd, vecs[k].rv, vecs[k].rtag, vecs[k].rrdy);
      #1;
      check("ready", 512'({req_ready_in, rsp_ready_in}), 512'({vecs[k].e_rdy, vecs[k].e_rrdy}));
      @(posedge clk);
      #1;
      check_outputs(vecs[k]);
    end

    // Fill both paths with the pointer parked at 3, then reset mid-transfer.
    @(negedge clk);
    drive(4'hF, T0, 1'b0, 1'b1, 18'h30007, 4'b0111);
    #1;
    check("load_a_ready", 512'({req_ready_in, rsp_ready_in}), 512'({4'b0010, 1'b1}));
    @(negedge clk);
    drive(4'hF, T0, 1'b0, 1'b1, 18'h3000B, 4'b0111);
    #1;
    check("load_b_ready", 512'({req_ready_in, rsp_ready_in}), 512'({4'b0100, 1'b1}));
    check("loaded_valids", 512'({req_valid_out, rsp_valid_out}), 512'({1'b1, 4'b1000}));
    @(negedge clk);
    reset = 1'b1;
    drive(4'hF, T0, 1'b0, 1'b1, 18'h00000, 4'b0111);
    #1;
    check("reset_cycle_ready", 512'({req_ready_in, rsp_ready_in}), 512'(0));
    @(posedge clk);
    #1;
    check("reset_valids", 512'({req_valid_out, rsp_valid_out}), 512'(0));
    @(negedge clk);
    reset = 1'b0;
    drive(4'b1010, T0, 1'b1, 1'b0, 18'h0, 4'hF);
    #1;
    check("post_reset_grant", 512'(req_ready_in), 512'(4'b0010));
    @(posedge clk);
    #1;
    check("post_reset_out", 512'({req_valid_out, req_tag_out}), 512'({1'b1, 18'h08889}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
